// File: rtl/accum_burst_seq_if.sv
// Stream/control bundle of the accumulate-burst sequencer: start/len/bias/abort
// control, the input word stream, the result handshake and the busy flag.
interface accum_burst_seq_if #(
  parameter int DATA_W = 16,
  parameter int AUX_W  = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic [ACC_W-1:0]  bias;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AUX_W-1:0]  in_aux;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;
  logic              busy;

  // Sequencer side.
  modport slave (
    input  start, len, bias, abort, in_valid, in_data, in_aux, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_ovf, busy
  );

  // Controller / producer / consumer side.
  modport master (
    output start, len, bias, abort, in_valid, in_data, in_aux, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_ovf, busy
  );
endinterface

// File: rtl/accum_burst_seq.sv
// Burst sequencer for the shared accumulate datapath (Z <= Z + bus_out + w2).
// A start loads the bias, len words are accumulated over a valid/ready stream,
// then sum, word count and sticky carry are offered on a result handshake.
module accum_burst_seq #(
  parameter int DATA_W = 16,
  parameter int AUX_W  = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  accum_burst_seq_if.slave   bus
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_ovf_q;
  logic             busy_q;

  logic [SUM_W-1:0] sum_d;
  logic             accept_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             last_d;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;

  // Datapath next values for the word offered this cycle (used only in RUN).
  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    sum_d     = {1'b0, acc_q} + SUM_W'(bus.in_data) + SUM_W'(bus.in_aux);
    accept_d  = in_ready_q & bus.in_valid;
    cnt_inc_d = cnt_q + CNT_W'(1);
    last_d    = accept_d && (cnt_inc_d == len_q);
    acc_d     = accept_d ? sum_d[ACC_W-1:0] : acc_q;
    cnt_d     = accept_d ? cnt_inc_d : cnt_q;
    ovf_d     = ovf_q | (accept_d & sum_d[ACC_W]);
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked block, and all state uses <= so
    // every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q  <= bus.bias;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            len_q  <= bus.len;
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end else begin
              // Empty burst: the bias itself is the result.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_acc_q   <= bus.bias;
              out_cnt_q   <= '0;
              out_ovf_q   <= 1'b0;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
          // An abort coinciding with an accept still keeps that word.
          if (last_d || bus.abort) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_acc_q   <= acc_d;
            out_cnt_q   <= cnt_d;
            out_ovf_q   <= ovf_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_accum_burst_seq.sv
// Self-checking bench for accum_burst_seq. The reference model is the burst
// total bias + sum(data+aux) held in 64 bits: the result is its low 32 bits
// and the sticky carry is set exactly when that total reached 2^32.
module tb_accum_burst_seq;

  localparam int DATA_W = 16;
  localparam int AUX_W  = 8;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  accum_burst_seq_if #(.DATA_W(DATA_W), .AUX_W(AUX_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  accum_burst_seq #(.DATA_W(DATA_W), .AUX_W(AUX_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: result expected for the burst in flight, and the last result
  // handed over (what out_* must hold while idle).
  logic [63:0] exp_total = '0;
  int          exp_cnt   = 0;
  bit          exp_armed = 1'b0;
  logic [31:0] last_acc  = '0;
  int          last_cnt  = 0;
  bit          last_ovf  = 1'b0;
  int          start_cyc = 0;

  function automatic logic [31:0] m_acc();
    return exp_total[31:0];
  endfunction

  function automatic bit m_ovf();
    return exp_total[63:32] != '0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: results while out_valid, held values while idle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        check("cmp_armed", 64'(exp_armed), 64'd1);
        check("cmp_acc", bus.out_acc, m_acc());
        check("cmp_cnt", bus.out_cnt, exp_cnt);
        check("cmp_ovf", bus.out_ovf, m_ovf());
        check("cmp_rdy_done", bus.in_ready, 0);
      end else if (!bus.busy) begin
        check("idle_acc", bus.out_acc, last_acc);
        check("idle_cnt", bus.out_cnt, last_cnt);
        check("idle_ovf", bus.out_ovf, last_ovf);
        check("idle_rdy", bus.in_ready, 0);
      end
    end
  end

  task automatic start_burst(input int len, input logic [31:0] bias);
    start_cyc    = cyc;
    bus.start    = 1'b1;
    bus.len      = CNT_W'(len);
    bus.bias     = bias;
    exp_total    = 64'(bias);
    exp_cnt      = 0;
    exp_armed    = 1'b1;
    tick();
    bus.start    = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_rdy", bus.in_ready, (len != 0));
    check("start_valid", bus.out_valid, (len == 0));
  endtask

  task automatic send_word(input int d, input int a, input bit ab);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(d);
    bus.in_aux   = AUX_W'(a);
    bus.abort    = ab;
    check("word_rdy", bus.in_ready, 1);
    exp_total    = exp_total + 64'(d) + 64'(a);
    exp_cnt++;
    tick();
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      tick();
      check("gap_rdy", bus.in_ready, 1);
    end
  endtask

  // Holds out_ready low for 'hold' cycles, then completes the handshake.
  task automatic finish_burst(input int hold);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      tick();
      check("hold_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_armed = 1'b0;
    last_acc  = m_acc();
    last_cnt  = exp_cnt;
    last_ovf  = m_ovf();
    check("hs_valid_low", bus.out_valid, 0);
    check("hs_idle", bus.busy, 0);
  endtask

  int w_d [3] = '{10, 20, 30};
  int w_a [3] = '{1, 2, 3};

  initial begin
    bus.start = 0; bus.len = '0; bus.bias = '0; bus.abort = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_aux = '0; bus.out_ready = 0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_rdy", bus.in_ready, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_acc", bus.out_acc, 0);
    check("rst_cnt", bus.out_cnt, 0);
    check("rst_ovf", bus.out_ovf, 0);
    rst = 1'b0;

    // Abort while idle does nothing.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle_abort_busy", bus.busy, 0);

    // 1: back-to-back burst. The start cycle counts as cycle 1, so out_valid
    // appears in cycle 5 (N+2 for N=3).
    start_burst(3, 100);
    for (int i = 0; i < 3; i++) send_word(w_d[i], w_a[i], 1'b0);
    check("t1_valid", bus.out_valid, 1);
    check("t1_latency", cyc - start_cyc + 1, 5);
    check("t1_acc_lit", bus.out_acc, 166);
    check("t1_cnt_lit", bus.out_cnt, 3);
    check("t1_ovf_lit", bus.out_ovf, 0);
    finish_burst(0);

    // 2: same words with stream gaps, consumer stalls 4 cycles.
    start_burst(3, 100);
    gap(1);
    send_word(w_d[0], w_a[0], 1'b0);
    gap(2);
    send_word(w_d[1], w_a[1], 1'b0);
    gap(1);
    send_word(w_d[2], w_a[2], 1'b0);
    check("t2_valid", bus.out_valid, 1);
    check("t2_acc_lit", bus.out_acc, 166);
    finish_burst(4);

    // 3: carry out of the accumulator.
    start_burst(1, 32'hFFFF_FFF0);
    send_word(16'h0020, 0, 1'b0);
    check("t3_acc_lit", bus.out_acc, 32'h0000_0010);
    check("t3_ovf_lit", bus.out_ovf, 1);
    finish_burst(1);

    // 4: abort with the accept of word 2; stray starts in RUN and DONE.
    start_burst(5, 0);
    bus.start = 1'b1; bus.len = 8'd9; bus.bias = 32'd999;
    send_word(5, 0, 1'b0);
    bus.start = 1'b0;
    send_word(7, 0, 1'b1);
    check("t4_valid", bus.out_valid, 1);
    check("t4_cnt_lit", bus.out_cnt, 2);
    check("t4_acc_lit", bus.out_acc, 12);
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t4_done_hold", bus.out_valid, 1);
    bus.out_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.out_ready = 1'b0; bus.start = 1'b0;
    exp_armed = 1'b0;
    last_acc = m_acc(); last_cnt = exp_cnt; last_ovf = m_ovf();
    check("t4_hs_idle", bus.busy, 0);
    tick();
    check("t4_start_ignored", bus.busy, 0);

    // 5: empty burst; words offered in DONE are not consumed; carry cleared.
    bus.in_valid = 1'b1; bus.in_data = 16'd55; bus.in_aux = 8'd5;
    start_cyc = cyc;
    bus.start = 1'b1; bus.len = '0; bus.bias = 32'd42;
    exp_total = 64'd42; exp_cnt = 0; exp_armed = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t5_valid", bus.out_valid, 1);
    check("t5_latency", cyc - start_cyc, 1);
    check("t5_rdy", bus.in_ready, 0);
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("t5_acc_lit", bus.out_acc, 42);
    check("t5_cnt_lit", bus.out_cnt, 0);
    check("t5_ovf_lit", bus.out_ovf, 0);
    finish_burst(0);

    // 6: reset mid-RUN, then a clean burst from a new bias.
    start_burst(4, 7);
    send_word(3, 1, 1'b0);
    send_word(4, 2, 1'b0);
    rst = 1'b1;
    tick();
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_rdy", bus.in_ready, 0);
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_acc", bus.out_acc, 0);
    check("t6_rst_cnt", bus.out_cnt, 0);
    check("t6_rst_ovf", bus.out_ovf, 0);
    exp_armed = 1'b0;
    last_acc = '0; last_cnt = 0; last_ovf = 1'b0;
    rst = 1'b0;
    tick();
    start_burst(1, 1000);
    send_word(1, 2, 1'b0);
    check("t6_acc_lit", bus.out_acc, 1003);
    check("t6_cnt_lit", bus.out_cnt, 1);
    finish_burst(2);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
